// File: rtl/sensor_poll_scheduler_pkg.sv
// rtl/sensor_poll_scheduler_pkg.sv - shared types and constants for the sensor poll scheduler
package sensor_poll_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_TRIGGER,
        ST_WAIT_MEAS,
        ST_REQUEST,
        ST_CAPTURE,
        ST_NEXT
    } poll_state_t;

endpackage

// File: rtl/sensor_poll_scheduler_if.sv
// rtl/sensor_poll_scheduler_if.sv - handshake bus between scheduler and sensor comm block
interface sensor_poll_if #(
    parameter int SEL_W = 2
);
    import sensor_poll_pkg::*;

    logic                meas_start;
    logic [SEL_W-1:0]    sensor_sel;
    logic                meas_ready;
    logic                request_data;
    logic                data_ready;
    logic [SAMPLE_W-1:0] data_in;

    // Scheduler side
    modport master (
        output meas_start,
        output sensor_sel,
        output request_data,
        input  meas_ready,
        input  data_ready,
        input  data_in
    );

    // Comm block side
    modport slave (
        input  meas_start,
        input  sensor_sel,
        input  request_data,
        output meas_ready,
        output data_ready,
        output data_in
    );

endinterface

// File: rtl/sensor_poll_scheduler_tick_gen.sv
// rtl/sensor_poll_scheduler_tick_gen.sv - round-start tick divider with pending flag and overrun detect
module poll_tick_gen #(
    parameter int POLL_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic consume,
    input  logic clr_err,
    output logic pending,
    output logic overrun
);

    localparam int CNT_W = $clog2(POLL_DIV);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = enable && (cnt == CNT_W'(POLL_DIV - 1));

    // Free-running divider and single-entry pending flag; a tick landing on an
    // unconsumed pending flag is recorded as a sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (!enable) begin
                cnt     <= '0;
                pending <= 1'b0;
            end else begin
                cnt     <= tick ? '0 : cnt + 1'b1;
                pending <= (pending && !consume) || tick;
            end
            if (tick && pending && !consume) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// rtl/sensor_poll_scheduler.sv - round-robin distance sensor polling FSM with timeouts and key decisions
module sensor_poll_scheduler
    import sensor_poll_pkg::*;
#(
    parameter  int NUM_SENSORS = 4,
    parameter  int POLL_DIV    = 100000,
    parameter  int TIMEOUT     = 4096,
    localparam int SEL_W       = $clog2(NUM_SENSORS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [SAMPLE_W-1:0]    threshold,
    input  logic                   clr_err,
    sensor_poll_if.master          bus,
    output logic                   sample_valid,
    output logic [SEL_W-1:0]       sample_ch,
    output logic [SAMPLE_W-1:0]    sample_data,
    output logic [NUM_SENSORS-1:0] key_mask,
    output logic [NUM_SENSORS-1:0] err_mask,
    output logic                   round_done,
    output logic                   overrun
);

    localparam int TMO_W = $clog2(TIMEOUT);

    poll_state_t      state;
    logic [SEL_W-1:0] ch;
    logic [TMO_W-1:0] tmo;
    logic             failed;
    logic             meas_start;
    logic             request_data;
    logic             pending;
    logic             consume;
    logic             last_ch;
    logic             tmo_last;

    assign consume  = (state == ST_WAIT_TICK) && enable && pending;
    assign last_ch  = (ch == SEL_W'(NUM_SENSORS - 1));
    assign tmo_last = (tmo == TMO_W'(TIMEOUT - 1));

    assign bus.meas_start   = meas_start;
    assign bus.request_data = request_data;
    assign bus.sensor_sel   = ch;

    poll_tick_gen #(
        .POLL_DIV (POLL_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .consume (consume),
        .clr_err (clr_err),
        .pending (pending),
        .overrun (overrun)
    );

    // Scan sequencer: one channel at a time, every wait bounded by the timeout
    // counter so a dead sensor only costs its own slot in the round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ch           <= '0;
            tmo          <= '0;
            failed       <= 1'b0;
            meas_start   <= 1'b0;
            request_data <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            key_mask     <= '0;
            err_mask     <= '0;
            round_done   <= 1'b0;
        end else begin
            meas_start   <= 1'b0;
            sample_valid <= 1'b0;
            round_done   <= 1'b0;
            // a bit set later in this block overrides the clear
            if (clr_err) begin
                err_mask <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_WAIT_TICK;
                    end
                end
                ST_WAIT_TICK: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (pending) begin
                        ch         <= '0;
                        meas_start <= 1'b1;
                        state      <= ST_TRIGGER;
                    end
                end
                ST_TRIGGER: begin
                    tmo   <= '0;
                    state <= ST_WAIT_MEAS;
                end
                ST_WAIT_MEAS: begin
                    if (bus.meas_ready) begin
                        tmo          <= '0;
                        request_data <= 1'b1;
                        state        <= ST_REQUEST;
                    end else if (tmo_last) begin
                        failed     <= 1'b1;
                        round_done <= last_ch;
                        state      <= ST_NEXT;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_REQUEST: begin
                    if (bus.data_ready) begin
                        request_data <= 1'b0;
                        sample_valid <= 1'b1;
                        sample_ch    <= ch;
                        sample_data  <= bus.data_in;
                        key_mask[ch] <= (bus.data_in >= threshold);
                        state        <= ST_CAPTURE;
                    end else if (tmo_last) begin
                        request_data <= 1'b0;
                        failed       <= 1'b1;
                        round_done   <= last_ch;
                        state        <= ST_NEXT;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    round_done <= last_ch;
                    state      <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (failed) begin
                        err_mask[ch] <= 1'b1;
                        key_mask[ch] <= 1'b0;
                    end
                    failed <= 1'b0;
                    if (last_ch) begin
                        state <= ST_WAIT_TICK;
                    end else begin
                        ch         <= ch + 1'b1;
                        meas_start <= 1'b1;
                        state      <= ST_TRIGGER;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// tb/tb_sensor_poll_scheduler.sv - randomized self-checking bench with behavioural reference model
module tb_sensor_poll_scheduler;

    localparam int N    = 4;
    localparam int PDIV = 64;
    localparam int TMO  = 8;

    localparam int P_IDLE = 0, P_WAIT = 1, P_TRIG = 2, P_MEAS = 3, P_REQ = 4, P_CAP = 5, P_NEXT = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] threshold = 8'h00;
    logic       sample_valid;
    logic [1:0] sample_ch;
    logic [7:0] sample_data;
    logic [3:0] key_mask;
    logic [3:0] err_mask;
    logic       round_done;
    logic       overrun;

    sensor_poll_if #(.SEL_W(2)) bus ();

    sensor_poll_scheduler #(
        .NUM_SENSORS (N),
        .POLL_DIV    (PDIV),
        .TIMEOUT     (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .threshold    (threshold),
        .clr_err      (clr_err),
        .bus          (bus),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .key_mask     (key_mask),
        .err_mask     (err_mask),
        .round_done   (round_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // sensor responder configuration
    int         mdly [N];
    int         ddly [N];
    logic [7:0] dval [N];
    int         mcount = -1;
    int         rcount = 0;
    int         cur = 0;

    // behavioural model state
    int         m_ph = P_IDLE;
    int         m_ch = 0;
    int         m_wait = 0;
    bit         m_fail = 0;
    int         m_tcnt = 0;
    bit         m_pend = 0;
    bit         m_ovr = 0;
    logic [3:0] m_key = '0;
    logic [3:0] m_err = '0;
    logic [7:0] m_sdata = '0;
    int         m_sch = 0;

    // observation counters
    int sv_cnt = 0, ms_cnt = 0, rd_cnt = 0, last_sch = 0, req_run = 0, req_max = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_ch = 0; m_wait = 0; m_fail = 0; m_tcnt = 0; m_pend = 0;
        m_ovr = 0; m_key = '0; m_err = '0; m_sdata = '0; m_sch = 0;
    endtask

    // one clock edge of the specified behaviour, using input values seen at the edge
    task automatic model_step();
        bit en, consume, tick;
        en      = enable;
        consume = (m_ph == P_WAIT) && en && m_pend;
        tick    = 1'b0;
        if (en) begin
            m_tcnt++;
            if (m_tcnt == PDIV) begin
                tick   = 1'b1;
                m_tcnt = 0;
            end
        end else begin
            m_tcnt = 0;
        end
        if (clr_err) begin
            m_ovr = 0;
            m_err = '0;
        end
        if (tick && m_pend && !consume) m_ovr = 1;
        m_pend = en && ((m_pend && !consume) || tick);
        case (m_ph)
            P_IDLE: if (en) m_ph = P_WAIT;
            P_WAIT: begin
                if (!en) m_ph = P_IDLE;
                else if (consume) begin m_ch = 0; m_ph = P_TRIG; end
            end
            P_TRIG: begin m_wait = 0; m_ph = P_MEAS; end
            P_MEAS: begin
                if (bus.meas_ready) begin m_wait = 0; m_ph = P_REQ; end
                else begin
                    m_wait++;
                    if (m_wait == TMO) begin m_fail = 1; m_ph = P_NEXT; end
                end
            end
            P_REQ: begin
                if (bus.data_ready) begin
                    m_sdata     = bus.data_in;
                    m_sch       = m_ch;
                    m_key[m_ch] = (bus.data_in >= threshold);
                    m_ph        = P_CAP;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin m_fail = 1; m_ph = P_NEXT; end
                end
            end
            P_CAP: m_ph = P_NEXT;
            default: begin
                if (m_fail) begin m_err[m_ch] = 1'b1; m_key[m_ch] = 1'b0; end
                m_fail = 0;
                if (m_ch == N - 1) m_ph = P_WAIT;
                else begin m_ch++; m_ph = P_TRIG; end
            end
        endcase
    endtask

    // sensor comm block stand-in: meas_ready after mdly cycles, data_ready pulse after ddly cycles
    task automatic respond();
        bus.data_ready = 1'b0;
        bus.data_in    = 8'($urandom);
        if (!rst_n) begin
            bus.meas_ready = 1'b0;
            mcount = -1;
            rcount = 0;
            return;
        end
        if (bus.meas_start) begin
            bus.meas_ready = 1'b0;
            mcount = 0;
            cur    = int'(bus.sensor_sel);
        end else if (mcount >= 0) begin
            mcount++;
            if (mcount >= mdly[cur]) begin
                bus.meas_ready = 1'b1;
                mcount = -1;
            end
        end
        if (bus.request_data) begin
            rcount++;
            if (rcount == ddly[cur]) begin
                bus.data_ready = 1'b1;
                bus.data_in    = dval[cur];
            end
        end else begin
            rcount = 0;
        end
    endtask

    // model advance and responder drive, once per clock
    initial begin
        bus.meas_ready = 1'b0;
        bus.data_ready = 1'b0;
        bus.data_in    = 8'h00;
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            respond();
        end
    end

    // every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("meas_start",   bus.meas_start,   m_ph == P_TRIG);
            chk("request_data", bus.request_data, m_ph == P_REQ);
            chk("sensor_sel",   bus.sensor_sel,   m_ch);
            chk("sample_valid", sample_valid,     m_ph == P_CAP);
            chk("sample_ch",    sample_ch,        m_sch);
            chk("sample_data",  sample_data,      m_sdata);
            chk("key_mask",     key_mask,         m_key);
            chk("err_mask",     err_mask,         m_err);
            chk("round_done",   round_done,       (m_ph == P_NEXT) && (m_ch == N - 1));
            chk("overrun",      overrun,          m_ovr);
            if (sample_valid) begin sv_cnt++; last_sch = int'(sample_ch); end
            if (bus.meas_start) ms_cnt++;
            if (round_done) rd_cnt++;
            if (bus.request_data) req_run++;
            else begin
                if (req_run > req_max) req_max = req_run;
                req_run = 0;
            end
        end
    end

    task automatic wait_round(input string name, input int budget);
        int r0, n;
        r0 = rd_cnt;
        n  = 0;
        while (rd_cnt == r0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, rd_cnt != r0, 1);
    endtask

    task automatic idle_and_clear();
        @(posedge clk); #1 enable = 1'b0;
        repeat (4) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_delays(input int md, input int dd);
        for (int i = 0; i < N; i++) begin mdly[i] = md; ddly[i] = dd; end
    endtask

    initial begin
        int sv0, ms0, n;
        set_delays(3, 3);
        dval[0] = 8'h10; dval[1] = 8'h80; dval[2] = 8'h7F; dval[3] = 8'hFF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_key_mask", key_mask, 4'b0000);
        chk("reset_err_mask", err_mask, 4'b0000);
        chk("reset_request",  bus.request_data, 1'b0);
        chk("reset_valid",    sample_valid, 1'b0);

        // basic round, threshold exactly equal to one sample
        threshold = 8'h80;
        sv0 = sv_cnt;
        enable = 1'b1;
        wait_round("round1_done", 400);
        enable = 1'b0;
        chk("round1_samples", sv_cnt - sv0, 4);
        chk("round1_key_mask", key_mask, 4'b1010);
        chk("round1_err_mask", err_mask, 4'b0000);
        chk("round1_last_ch", last_sch, 3);
        chk("round1_last_data", sample_data, 8'hFF);
        idle_and_clear();

        // data_ready coinciding with the timeout cycle wins
        dval[0] = 8'h90; dval[1] = 8'h20; dval[2] = 8'hC0; dval[3] = 8'h80;
        set_delays(2, 2);
        ddly[0] = TMO;
        sv0 = sv_cnt;
        enable = 1'b1;
        wait_round("edge_done", 400);
        enable = 1'b0;
        chk("edge_samples", sv_cnt - sv0, 4);
        chk("edge_err_mask", err_mask, 4'b0000);
        chk("edge_key_mask", key_mask, 4'b1101);
        idle_and_clear();

        // sensor 2 never reports ready
        set_delays(3, 3);
        mdly[2] = 99;
        sv0 = sv_cnt;
        enable = 1'b1;
        wait_round("stuck_done", 400);
        enable = 1'b0;
        chk("stuck_err_mask", err_mask, 4'b0100);
        chk("stuck_key_mask", key_mask, 4'b1001);
        chk("stuck_samples", sv_cnt - sv0, 3);
        chk("stuck_last_ch", last_sch, 3);
        idle_and_clear();

        // data_ready withheld on sensor 1: request held exactly TMO cycles
        set_delays(2, 2);
        ddly[1] = 99;
        req_max = 0;
        enable = 1'b1;
        wait_round("req_tmo_done", 400);
        enable = 1'b0;
        chk("req_tmo_len", req_max, TMO);
        chk("req_tmo_err_mask", err_mask, 4'b0010);
        idle_and_clear();
        chk("clr_err_mask", err_mask, 4'b0000);

        // slow sensors: rounds longer than the tick period, meas_ready on the timeout cycle
        dval[0] = 8'h90; dval[1] = 8'h20; dval[2] = 8'hC0; dval[3] = 8'h80;
        set_delays(TMO, TMO);
        enable = 1'b1;
        for (int r = 0; r < 5; r++) wait_round("slow_done", 400);
        chk("slow_overrun", overrun, 1'b1);
        chk("slow_err_mask", err_mask, 4'b0000);
        wait_round("slow_done", 400);
        ms0 = ms_cnt;
        n = 0;
        while (ms_cnt == ms0 && n < 20) begin @(posedge clk); n++; end
        chk("slow_back_to_back", n, 2);
        @(posedge clk); #1 enable = 1'b0;
        wait_round("slow_drain", 400);
        idle_and_clear();
        chk("clr_overrun", overrun, 1'b0);

        // asynchronous reset while request_data is held
        set_delays(2, 6);
        enable = 1'b1;
        n = 0;
        while (!bus.request_data && n < 300) begin @(posedge clk); #1; n++; end
        chk("rst_req_seen", bus.request_data, 1'b1);
        chk("rst_key_before", key_mask, 4'b1101);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_request", bus.request_data, 1'b0);
        chk("rst_meas_start", bus.meas_start, 1'b0);
        chk("rst_key_mask", key_mask, 4'b0000);
        chk("rst_err_mask", err_mask, 4'b0000);
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // enable dropped mid-round: round completes, then no further triggers
        set_delays(3, 3);
        #1 enable = 1'b1;
        n = 0;
        while (!(bus.meas_start && bus.sensor_sel == 2'd1) && n < 300) begin @(posedge clk); #1; n++; end
        chk("mid_trigger_seen", bus.meas_start, 1'b1);
        enable = 1'b0;
        wait_round("mid_done", 400);
        ms0 = ms_cnt;
        repeat (150) @(posedge clk);
        #1;
        chk("mid_no_restart", ms_cnt - ms0, 0);

        // randomized traffic
        enable = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            clr_err = ($urandom_range(0, 39) == 0);
            if (enable) begin
                if ($urandom_range(0, 299) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                enable = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) threshold = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                int k;
                k = $urandom_range(0, N - 1);
                mdly[k] = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(1, TMO + 2);
                ddly[k] = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(1, TMO + 2);
                dval[k] = 8'($urandom);
            end
        end
        clr_err = 1'b0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
